// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and branch target adder.
// Define EXE_MUL_UNIT_EN to build the multi-cycle shift-add multiplier (EXE_CMD=10).
module exe_stage #(
  parameter int WORD_LEN          = 32,
  parameter int EXE_CMD_LEN       = 4,
  parameter int REG_FILE_ADDR_LEN = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [EXE_CMD_LEN-1:0]       EXE_CMD,
  input  logic [WORD_LEN-1:0]          val1,
  input  logic [WORD_LEN-1:0]          val2,
  input  logic [WORD_LEN-1:0]          ST_value,
  input  logic [WORD_LEN-1:0]          PC,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest,
  input  logic                         is_imm,
  input  logic                         MEM_R_EN,
  input  logic                         MEM_W_EN,
  input  logic                         WB_EN,
  input  logic                         brTaken,
  input  logic                         mem_wb_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
  input  logic [WORD_LEN-1:0]          mem_value,
  input  logic                         wb_wb_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
  input  logic [WORD_LEN-1:0]          wb_value,
  output logic [WORD_LEN-1:0]          alu_res,
  output logic [WORD_LEN-1:0]          st_value_out,
  output logic [WORD_LEN-1:0]          br_addr,
  output logic                         stall
);

  localparam logic [EXE_CMD_LEN-1:0] CMD_MUL = 4'd10;

  logic [WORD_LEN-1:0] op_a, op_b, alu_comb;

  // Control bits travel alongside this stage; they are not consumed here.
  logic unused_ctrl;
  assign unused_ctrl = ^{MEM_R_EN, MEM_W_EN, WB_EN, brTaken, dest};

  // MEM beats WB; register 0 is never a forwarding target.
  function automatic logic [WORD_LEN-1:0] fwd(
    input logic [REG_FILE_ADDR_LEN-1:0] src,
    input logic [WORD_LEN-1:0]          dflt,
    input logic                         m_en,
    input logic [REG_FILE_ADDR_LEN-1:0] m_dest,
    input logic [WORD_LEN-1:0]          m_val,
    input logic                         w_en,
    input logic [REG_FILE_ADDR_LEN-1:0] w_dest,
    input logic [WORD_LEN-1:0]          w_val
  );
    if (src != '0 && m_en && m_dest == src)      return m_val;
    else if (src != '0 && w_en && w_dest == src) return w_val;
    else                                          return dflt;
  endfunction

  always_comb begin
    op_a         = fwd(src1, val1, mem_wb_en, mem_dest, mem_value, wb_wb_en, wb_dest, wb_value);
    op_b         = is_imm ? val2
                 : fwd(src2, val2, mem_wb_en, mem_dest, mem_value, wb_wb_en, wb_dest, wb_value);
    st_value_out = fwd(src2, ST_value, mem_wb_en, mem_dest, mem_value, wb_wb_en, wb_dest, wb_value);
  end

  assign br_addr = PC + val2;

  always_comb begin
    alu_comb = '0;
    case (EXE_CMD)
      4'd1:    alu_comb = op_a + op_b;
      4'd2:    alu_comb = op_a - op_b;
      4'd3:    alu_comb = op_a & op_b;
      4'd4:    alu_comb = op_a | op_b;
      4'd5:    alu_comb = ~(op_a | op_b);
      4'd6:    alu_comb = op_a ^ op_b;
      4'd7:    alu_comb = op_a << op_b[4:0];
      4'd8:    alu_comb = op_a >> op_b[4:0];
      4'd9:    alu_comb = $unsigned($signed(op_a) >>> op_b[4:0]);
      default: alu_comb = '0;
    endcase
  end

`ifdef EXE_MUL_UNIT_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t          state_reg;
  logic [4:0]          cnt_reg;
  logic [WORD_LEN-1:0] mul_a_reg, mul_b_reg, prod_reg;

  // One shift-add step per BUSY cycle: multiplicand shifts left, multiplier right.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      prod_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (EXE_CMD == CMD_MUL) begin
            mul_a_reg <= op_a;
            mul_b_reg <= op_b;
            prod_reg  <= '0;
            cnt_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (mul_b_reg[0]) prod_reg <= prod_reg + mul_a_reg;
          mul_a_reg <= mul_a_reg << 1;
          mul_b_reg <= mul_b_reg >> 1;
          cnt_reg   <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset overrides the FSM so that outputs fall back to the combinational path.
  assign stall   = !rst && (state_reg == BUSY || (state_reg == IDLE && EXE_CMD == CMD_MUL));
  assign alu_res = (!rst && state_reg == DONE) ? prod_reg : alu_comb;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = ^{clk, rst, CMD_MUL};
  assign stall          = 1'b0;
  assign alu_res        = alu_comb;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized ALU/forwarding
// traffic against a behavioural model, and multiplier latency/reset checks.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic [31:0] val1, val2, ST_value, PC;
  logic [4:0]  src1, src2, dest;
  logic        is_imm, MEM_R_EN, MEM_W_EN, WB_EN, brTaken;
  logic        mem_wb_en, wb_wb_en;
  logic [4:0]  mem_dest, wb_dest;
  logic [31:0] mem_value, wb_value;
  logic [31:0] alu_res, st_value_out, br_addr;
  logic        stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD),
    .val1(val1), .val2(val2), .ST_value(ST_value), .PC(PC),
    .src1(src1), .src2(src2), .dest(dest), .is_imm(is_imm),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .brTaken(brTaken),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_value(mem_value),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .alu_res(alu_res), .st_value_out(st_value_out), .br_addr(br_addr), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: register lookup with MEM-over-WB priority, r0 never forwarded.
  function automatic logic [31:0] m_fwd(input logic [4:0] s, input logic [31:0] dflt);
    if (s == 0) return dflt;
    if (mem_wb_en && mem_dest == s) return mem_value;
    if (wb_wb_en && wb_dest == s) return wb_value;
    return dflt;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh  = int'(b % 32);
    ext = {{32{a[31]}}, a};
    case (cmd)
      4'd1: return 32'(64'(a) + 64'(b));
      4'd2: return 32'(64'(a) + 64'(~b) + 64'd1);
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return ~a & ~b;
      4'd6: return (a | b) & ~(a & b);
      4'd7: return 32'(64'(a) * (64'd1 << sh));
      4'd8: return 32'(64'(a) / (64'd1 << sh));
      4'd9: return ext[sh +: 32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic quiet_inputs();
    EXE_CMD = 4'd0; val1 = 0; val2 = 0; ST_value = 0; PC = 0;
    src1 = 0; src2 = 0; dest = 0; is_imm = 0;
    MEM_R_EN = 0; MEM_W_EN = 0; WB_EN = 0; brTaken = 0;
    mem_wb_en = 0; mem_dest = 0; mem_value = 0;
    wb_wb_en = 0; wb_dest = 0; wb_value = 0;
  endtask

`ifdef EXE_MUL_UNIT_EN
  // Issues one MUL and reports stall-cycle count and the result seen on the first non-stall cycle.
  task automatic mul_run(input logic [31:0] a, input logic [31:0] b,
                         output int n_stall, output logic [31:0] res, output logic ok);
    @(negedge clk);
    quiet_inputs();
    EXE_CMD = 4'd10; val1 = a; val2 = b; src1 = 5'd4; src2 = 5'd5;
    n_stall = 0; ok = 1'b0; res = 'x;
    for (int c = 0; c < 40 && !ok; c++) begin
      #2;
      if (stall) begin
        n_stall++;
        @(negedge clk);
        val1 = $urandom; val2 = $urandom;
        mem_wb_en = 1'b1; mem_dest = 5'd4; mem_value = $urandom;
      end else begin
        res = alu_res;
        ok  = 1'b1;
      end
    end
  endtask
`endif

  initial begin
    logic [31:0] a, b, ra, rb;
    quiet_inputs();

    // Reset with MUL presented: stall held low, outputs combinational.
    rst = 1'b1; EXE_CMD = 4'd10; val1 = 6; val2 = 7; PC = 32'h100;
    @(negedge clk); #2;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mul_alu", alu_res, 32'd0);
    check("rst_br_addr", br_addr, 32'h107);
    @(negedge clk);
    EXE_CMD = 4'd1; val1 = 5; val2 = 7; #2;
    check("rst_add_comb", alu_res, 32'd12);
    @(negedge clk);
    rst = 1'b0; quiet_inputs();

    // Directed: ADD 5+7.
    EXE_CMD = 4'd1; val1 = 5; val2 = 7; src1 = 5'd1; src2 = 5'd2; #2;
    check("add_5_7", alu_res, 32'd12);
    check("add_stall", {31'd0, stall}, 32'd0);

    // Directed: MEM beats WB, and r0 never forwards.
    @(negedge clk); quiet_inputs();
    EXE_CMD = 4'd4; val1 = 32'h1234; val2 = 0; src1 = 5'd3;
    mem_wb_en = 1; mem_dest = 5'd3; mem_value = 32'hAA;
    wb_wb_en = 1; wb_dest = 5'd3; wb_value = 32'hBB; #2;
    check("fwd_mem_prio", alu_res, 32'hAA);
    src1 = 5'd0; #1;
    check("fwd_r0", alu_res, 32'h1234);
    src1 = 5'd3; mem_wb_en = 0; #1;
    check("fwd_wb_only", alu_res, 32'hBB);

    // Directed: immediate B not forwarded, store data still forwarded.
    @(negedge clk); quiet_inputs();
    EXE_CMD = 4'd7; val1 = 1; val2 = 4; is_imm = 1; src2 = 5'd2; ST_value = 1;
    mem_wb_en = 1; mem_dest = 5'd2; mem_value = 9; #2;
    check("sll_imm", alu_res, 32'd16);
    check("st_fwd", st_value_out, 32'd9);

    // Directed wrap boundaries.
    @(negedge clk); quiet_inputs();
    EXE_CMD = 4'd2; val1 = 0; val2 = 1; PC = 32'hFFFF_FFFC; #2;
    check("sub_wrap", alu_res, 32'hFFFF_FFFF);
    check("br_wrap", br_addr, 32'hFFFF_FFFD);
    EXE_CMD = 4'd1; val1 = 32'hFFFF_FFFF; val2 = 2; #1;
    check("add_wrap", alu_res, 32'd1);
    EXE_CMD = 4'd9; val1 = 32'h8000_0000; val2 = 31; #1;
    check("sra_31", alu_res, 32'hFFFF_FFFF);

    // Randomized single-cycle traffic against the model (MUL excluded).
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      EXE_CMD = 4'($urandom_range(0, 15));
      if (EXE_CMD == 4'd10) EXE_CMD = 4'd11;
      val1 = $urandom; val2 = $urandom; ST_value = $urandom; PC = $urandom;
      src1 = 5'($urandom_range(0, 3)); src2 = 5'($urandom_range(0, 3));
      dest = 5'($urandom); is_imm = 1'($urandom);
      {MEM_R_EN, MEM_W_EN, WB_EN, brTaken} = 4'($urandom);
      mem_wb_en = 1'($urandom); mem_dest = 5'($urandom_range(0, 3)); mem_value = $urandom;
      wb_wb_en = 1'($urandom); wb_dest = 5'($urandom_range(0, 3)); wb_value = $urandom;
      #2;
      ra = m_fwd(src1, val1);
      rb = is_imm ? val2 : m_fwd(src2, val2);
      check($sformatf("rnd%0d_alu_cmd%0d", i, EXE_CMD), alu_res, m_alu(EXE_CMD, ra, rb));
      check($sformatf("rnd%0d_st", i), st_value_out, m_fwd(src2, ST_value));
      check($sformatf("rnd%0d_br", i), br_addr, 32'(64'(PC) + 64'(val2)));
      check($sformatf("rnd%0d_stall", i), {31'd0, stall}, 32'd0);
    end

`ifdef EXE_MUL_UNIT_EN
    begin
      int n; logic [31:0] r; logic ok;
      mul_run(32'hFFFF_FFFF, 32'd3, n, r, ok);
      check("mul_max_done", {31'd0, ok}, 32'd1);
      check("mul_max_stalls", 32'(n), 32'd33);
      check("mul_max_res", r, 32'hFFFF_FFFD);
      // Back-to-back: next MUL restarts from IDLE with full latency.
      for (int k = 0; k < 3; k++) begin
        a = $urandom; b = $urandom;
        mul_run(a, b, n, r, ok);
        check($sformatf("mul%0d_done", k), {31'd0, ok}, 32'd1);
        check($sformatf("mul%0d_stalls", k), 32'(n), 32'd33);
        check($sformatf("mul%0d_res", k), r, 32'(64'(a) * 64'(b)));
      end
      @(negedge clk); quiet_inputs(); #2;
      check("mul_after_nop_alu", alu_res, 32'd0);
      check("mul_after_nop_stall", {31'd0, stall}, 32'd0);

      // Reset on the 10th BUSY cycle aborts the multiply.
      @(negedge clk);
      EXE_CMD = 4'd10; val1 = 32'd123; val2 = 32'd456;
      for (int c = 0; c < 10; c++) @(negedge clk);
      #2;
      check("busy10_stall", {31'd0, stall}, 32'd1);
      rst = 1'b1; EXE_CMD = 4'd0; #1;
      check("busy_rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 36; c++) begin
        #2;
        check($sformatf("post_rst%0d_stall", c), {31'd0, stall}, 32'd0);
        check($sformatf("post_rst%0d_alu", c), alu_res, 32'd0);
        @(negedge clk);
      end
      mul_run(32'd6, 32'd7, n, r, ok);
      check("mul67_done", {31'd0, ok}, 32'd1);
      check("mul67_stalls", 32'(n), 32'd33);
      check("mul67_res", r, 32'd42);
      @(negedge clk); quiet_inputs();
    end
`else
    @(negedge clk); quiet_inputs();
    EXE_CMD = 4'd10; val1 = 6; val2 = 7;
    for (int c = 0; c < 36; c++) begin
      #2;
      check($sformatf("nomul%0d_alu", c), alu_res, 32'd0);
      check($sformatf("nomul%0d_stall", c), {31'd0, stall}, 32'd0);
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 WORD_LEN, 32, datapath width.
REQ-002 EXE_CMD_LEN, 4, command width.
REQ-003 REG_FILE_ADDR_LEN, 5, register address width.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 EXE_CMD  in  4  operation from ID/EXE register.
REQ-007 val1, val2, ST_value, PC  in  32 each  operands, store data and PC from ID/EXE register.
REQ-008 src1, src2, dest  in  5 each  source and destination register numbers.
REQ-009 is_imm  in  1  val2 is an immediate; no forwarding is applied to val2.
REQ-010 MEM_R_EN, MEM_W_EN, WB_EN, brTaken  in  1 each  control bits, passed through unchanged.
REQ-011 mem_wb_en, mem_dest, mem_value  in  1/5/32  MEM-stage forwarding source.
REQ-012 wb_wb_en, wb_dest, wb_value  in  1/5/32  WB-stage forwarding source.
REQ-013 alu_res  out  32  execution result.
REQ-014 st_value_out  out  32  forwarded store data.
REQ-015 br_addr  out  32  branch target, PC + val2 (mod 2^32).
REQ-016 stall  out  1  upstream hold request; the ID/EXE register and PC do not advance while it is 1.

Function
REQ-017 The forwarding mux for operand A SHALL select mem_value when mem_wb_en=1 and mem_dest==src1, else wb_value when wb_wb_en=1 and wb_dest==src1, else val1; MEM has priority over WB.
REQ-018 Operand B SHALL use the same rule with src2 when is_imm=0; when is_imm=1, operand B SHALL be val2 unchanged.
REQ-019 st_value_out SHALL use the same rule with src2 applied to ST_value, regardless of is_imm.
REQ-020 A source or destination address of 0 SHALL never match for forwarding.
REQ-021 EXE_CMD encoding and result:
- 0 NOP -> 0
- 1 ADD
- 2 SUB
- 3 AND
- 4 OR
- 5 NOR
- 6 XOR
- 7 SLL (A<<B[4:0])
- 8 SRL
- 9 SRA
- 10 MUL
- 11-15 -> 0
REQ-022 Commands 0-9 and 11-15 SHALL be combinational, with zero added latency and stall=0; ADD and SUB wrap modulo 2^32 and raise no overflow indication.
REQ-023 The MUL FSM SHALL have the states IDLE, BUSY and DONE.
REQ-024 In IDLE with EXE_CMD=10, stall SHALL be 1 combinationally, and at the next edge the forwarded operands are captured, a 5-bit counter is cleared, and the FSM enters BUSY.
REQ-025 In BUSY, stall SHALL be 1 and one shift-add step is performed per cycle; after the 32nd step (counter==31) the FSM enters DONE.
REQ-026 In DONE, stall SHALL be 0 and alu_res SHALL be the low 32 bits of the unsigned product; the FSM returns to IDLE at the next edge, regardless of EXE_CMD.
REQ-027 From the cycle MUL is first presented, stall SHALL be high for exactly 33 cycles, with the result on the 34th cycle.
REQ-028 Operand changes on the inputs during BUSY SHALL not affect the product.
REQ-029 Back-to-back MULs SHALL each take the full latency; the second MUL starts from IDLE.

Reset
REQ-030 With rst=1 at a clock edge, the FSM SHALL go to IDLE, and the counter and the product/operand registers SHALL clear to 0.
REQ-031 During and after reset, stall SHALL be 0, and alu_res, st_value_out and br_addr SHALL follow the combinational paths from the current inputs.
REQ-032 A reset in BUSY or DONE SHALL abort the multiply; no stale result appears afterward.

Configuration
REQ-033 With the macro EXE_MUL_UNIT_EN defined, the MUL FSM and its registers SHALL be present as in REQ-023 to REQ-029.
REQ-034 With EXE_MUL_UNIT_EN undefined, EXE_CMD=10 SHALL produce alu_res=0 with stall=0, and no multiplier state SHALL exist.

Verification
REQ-035 ADD with val1=5, val2=7 and no forwarding matches -> alu_res=12, stall=0.
REQ-036 src1=3, mem_wb_en=1, mem_dest=3, mem_value=0xAA, wb_wb_en=1, wb_dest=3, wb_value=0xBB, OR with val2=0 -> alu_res=0xAA; the same stimulus with src1=0 -> alu_res=val1.
REQ-037 is_imm=1, val2=4, src2=2 matching mem_dest=2 with mem_value=9, ST_value=1, SLL with A=1 -> alu_res=16, st_value_out=9.
REQ-038 (EXE_MUL_UNIT_EN defined) MUL with A=0xFFFFFFFF, B=3 -> stall high for 33 cycles, then alu_res=0xFFFFFFFD for one cycle.
REQ-039 (EXE_MUL_UNIT_EN defined) rst pulsed on the 10th BUSY cycle -> stall=0 from the next cycle and the FSM in IDLE; a MUL of 6*7 issued afterward -> alu_res=42.
REQ-040 (EXE_MUL_UNIT_EN undefined) MUL with A=6, B=7 -> alu_res=0 and stall never asserted.
